// File: rtl/id_pkg.sv
// Shared definitions for the decode stage: branch encodings, default sizes and the
// instruction-derived part of the ID/EX bundle.
package id_pkg;

   localparam int unsigned XLEN_DEF     = 32;
   localparam int unsigned NREG_DEF     = 32;
   localparam int unsigned LOAD_LAT_DEF = 1;
   localparam int unsigned CTRL_W_DEF   = 16;
   localparam int unsigned INSTR_W      = 32;
   localparam int unsigned FIELD_W      = 5;
   localparam int unsigned IMM_W        = 16;
   localparam int unsigned BR_OP_W      = 3;

   typedef enum logic [BR_OP_W-1:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BGEZ = 3'd3,
      BR_BGTZ = 3'd4,
      BR_BLEZ = 3'd5,
      BR_BLTZ = 3'd6,
      BR_RSVD = 3'd7
   } br_op_e;

   // Raw instruction fields carried in the ID/EX register; widening happens at the outputs.
   typedef struct packed {
      logic [FIELD_W-1:0] rs;
      logic [FIELD_W-1:0] rt;
      logic [FIELD_W-1:0] rd;
      logic [FIELD_W-1:0] sa;
      logic [IMM_W-1:0]   imm;
   } id_ex_instr_t;

   function automatic id_ex_instr_t decode_fields(input logic [INSTR_W-1:0] instr);
      id_ex_instr_t f;
      f.rs  = instr[25:21];
      f.rt  = instr[20:16];
      f.rd  = instr[15:11];
      f.sa  = instr[10:6];
      f.imm = instr[15:0];
      return f;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// NREG x XLEN register file with two asynchronous read ports and one clocked write port.
// Register 0 is never written and always reads as zero.
module id_regfile
   import id_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned NREG = NREG_DEF,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic            clk_i,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [AW-1:0]   raddr_a_i,
   input  logic [AW-1:0]   raddr_b_i,
   output logic [XLEN-1:0] rdata_a_c_o,
   output logic [XLEN-1:0] rdata_b_c_o
);

   logic [XLEN-1:0] mem_q [NREG];

   always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_c_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
   assign rdata_b_c_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register read with optional WB bypass, branch/jump target resolution,
// load-use hazard stalling and the ID/EX pipeline register. Define ID_FWD_WB_EN for WB bypass.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREG     = NREG_DEF,
   parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
   parameter int unsigned CTRL_W   = CTRL_W_DEF,
   localparam int unsigned AW      = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [INSTR_W-1:0]  instr_id,
   input  logic [XLEN-1:0]     next_pc_id,
   input  logic [CTRL_W-1:0]   ctrl_id,
   input  logic [BR_OP_W-1:0]  br_op_id,
   input  logic                memread_ex,
   input  logic [AW-1:0]       regwaddr_ex,
   input  logic                regwrite_wb,
   input  logic [AW-1:0]       regwaddr_wb,
   input  logic [XLEN-1:0]     regwdata_wb,
   input  logic                ex_ready,
   output logic                out_valid,
   output logic [CTRL_W-1:0]   ctrl_ex,
   output logic [XLEN-1:0]     rs_data_ex,
   output logic [XLEN-1:0]     rt_data_ex,
   output logic [XLEN-1:0]     imm_ex,
   output logic [XLEN-1:0]     sa_ex,
   output logic [XLEN-1:0]     next_pc_ex,
   output logic [AW-1:0]       rs_addr_ex,
   output logic [AW-1:0]       rt_addr_ex,
   output logic [AW-1:0]       rd_addr_ex,
   output logic                branch_taken,
   output logic [XLEN-1:0]     branch_addr,
   output logic [XLEN-1:0]     jump_addr,
   output logic [XLEN-1:0]     jr_addr,
   output logic                stall
);

   localparam int unsigned CNT_W = 2;

   id_ex_instr_t    fields_c;
   logic [AW-1:0]   rs_idx_c;
   logic [AW-1:0]   rt_idx_c;
   logic [XLEN-1:0] rf_rs_c;
   logic [XLEN-1:0] rf_rt_c;
   logic [XLEN-1:0] rs_val_c;
   logic [XLEN-1:0] rt_val_c;
   logic [XLEN-1:0] imm_sext_c;
   logic            wb_wr_c;
   logic            load_haz_c;
   logic            wb_haz_c;
   logic            haz_stall_c;
   logic            bp_stall_c;
   logic            br_cond_c;
   logic            unused_opcode_c;

   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
   logic [XLEN-1:0]   rs_data_q,   rs_data_d;
   logic [XLEN-1:0]   rt_data_q,   rt_data_d;
   logic [XLEN-1:0]   pc_q,        pc_d;
   id_ex_instr_t      fields_q,    fields_d;

   assign fields_c        = decode_fields(instr_id);
   assign rs_idx_c        = fields_c.rs[AW-1:0];
   assign rt_idx_c        = fields_c.rt[AW-1:0];
   assign imm_sext_c      = {{(XLEN-IMM_W){fields_c.imm[IMM_W-1]}}, fields_c.imm};
   assign wb_wr_c         = regwrite_wb & (regwaddr_wb != '0);
   assign unused_opcode_c = ^instr_id[31:26];

   id_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk_i       (clk),
      .we_i        (regwrite_wb),
      .waddr_i     (regwaddr_wb),
      .wdata_i     (regwdata_wb),
      .raddr_a_i   (rs_idx_c),
      .raddr_b_i   (rt_idx_c),
      .rdata_a_c_o (rf_rs_c),
      .rdata_b_c_o (rf_rt_c)
   );

`ifdef ID_FWD_WB_EN
   assign rs_val_c = (wb_wr_c && (regwaddr_wb == rs_idx_c)) ? regwdata_wb : rf_rs_c;
   assign rt_val_c = (wb_wr_c && (regwaddr_wb == rt_idx_c)) ? regwdata_wb : rf_rt_c;
   assign wb_haz_c = 1'b0;
`else
   // Without bypass a same-cycle WB to a source must wait one cycle for the write to land.
   assign rs_val_c = rf_rs_c;
   assign rt_val_c = rf_rt_c;
   assign wb_haz_c = in_valid & wb_wr_c &
                     ((regwaddr_wb == rs_idx_c) | (regwaddr_wb == rt_idx_c));
`endif

   assign load_haz_c  = in_valid & memread_ex & (regwaddr_ex != '0) &
                        ((regwaddr_ex == rs_idx_c) | (regwaddr_ex == rt_idx_c));
   assign haz_stall_c = load_haz_c | wb_haz_c | (cnt_q != '0);
   assign bp_stall_c  = out_valid_q & ~ex_ready;
   assign stall       = haz_stall_c | bp_stall_c;
   assign in_ready    = ~stall;

   // Load-use counter covers the remaining LOAD_LAT-1 stall cycles after detection.
   always_comb begin
      cnt_d = cnt_q;
      if (load_haz_c && (cnt_q == '0)) begin
         cnt_d = CNT_W'(LOAD_LAT - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_comb begin
      br_cond_c = 1'b0;
      case (br_op_e'(br_op_id))
         BR_BEQ:  br_cond_c = (rs_val_c == rt_val_c);
         BR_BNE:  br_cond_c = (rs_val_c != rt_val_c);
         BR_BGEZ: br_cond_c = ~rs_val_c[XLEN-1];
         BR_BGTZ: br_cond_c = ~rs_val_c[XLEN-1] & (rs_val_c != '0);
         BR_BLEZ: br_cond_c = rs_val_c[XLEN-1] | (rs_val_c == '0);
         BR_BLTZ: br_cond_c = rs_val_c[XLEN-1];
         default: br_cond_c = 1'b0;
      endcase
   end

   assign branch_taken = in_valid & ~stall & br_cond_c;
   assign branch_addr  = next_pc_id + (imm_sext_c << 2);
   assign jump_addr    = {next_pc_id[XLEN-1:28], instr_id[25:0], 2'b00};
   assign jr_addr      = rs_val_c;

   // ID/EX update: backpressure holds everything, a hazard inserts a bubble, else load.
   always_comb begin
      out_valid_d = out_valid_q;
      ctrl_d      = ctrl_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      pc_d        = pc_q;
      fields_d    = fields_q;
      if (!bp_stall_c) begin
         if (haz_stall_c) begin
            out_valid_d = 1'b0;
            ctrl_d      = '0;
         end else begin
            out_valid_d = in_valid;
            ctrl_d      = ctrl_id;
            rs_data_d   = rs_val_c;
            rt_data_d   = rt_val_c;
            pc_d        = next_pc_id;
            fields_d    = fields_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         ctrl_q      <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         pc_q        <= '0;
         fields_q    <= '0;
      end else begin
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         ctrl_q      <= ctrl_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         pc_q        <= pc_d;
         fields_q    <= fields_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign ctrl_ex    = ctrl_q;
   assign rs_data_ex = rs_data_q;
   assign rt_data_ex = rt_data_q;
   assign next_pc_ex = pc_q;
   assign imm_ex     = {{(XLEN-IMM_W){fields_q.imm[IMM_W-1]}}, fields_q.imm};
   assign sa_ex      = XLEN'(fields_q.sa);
   assign rs_addr_ex = fields_q.rs[AW-1:0];
   assign rt_addr_ex = fields_q.rt[AW-1:0];
   assign rd_addr_ex = fields_q.rd[AW-1:0];

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width (>=32).
REQ-002 Parameter NREG, default 32, register count (power of 2, >=2); AW=clog2(NREG).
REQ-003 Parameter LOAD_LAT, default 1, load-use stall cycles (1..4).
REQ-004 Parameter CTRL_W, default 16, opaque control bundle width.
REQ-005 Ports: clk in 1 clock; reset in 1, synchronous active-high.
REQ-006 in_valid in 1; in_ready out 1: instruction handshake from IF/ID.
REQ-007 instr_id in 32; next_pc_id in XLEN; ctrl_id in CTRL_W; br_op_id in 3 (0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz).
REQ-008 memread_ex in 1; regwaddr_ex in AW: EX-stage load info for hazard check.
REQ-009 regwrite_wb in 1; regwaddr_wb in AW; regwdata_wb in XLEN: writeback port.
REQ-010 ex_ready in 1: EX accepts ID/EX contents.
REQ-011 out_valid out 1; ctrl_ex out CTRL_W; rs_data_ex, rt_data_ex, imm_ex, sa_ex, next_pc_ex out XLEN; rs_addr_ex, rt_addr_ex, rd_addr_ex out AW: registered ID/EX bundle.
REQ-012 branch_taken out 1; branch_addr, jump_addr, jr_addr out XLEN; stall out 1: combinational.

Function
REQ-013 Fields: rs=instr[25:21], rt=[20:16], rd=[15:11], sa=[10:6] zero-extended, imm=[15:0] sign-extended to XLEN; register index = field[AW-1:0].
REQ-014 Register file NREG x XLEN, two async reads, one write on clk when regwrite_wb and regwaddr_wb!=0; register 0 reads 0.
REQ-015 branch_addr = next_pc_id + (imm<<2) mod 2^XLEN; jump_addr = {next_pc_id[XLEN-1:28], instr[25:0], 2'b00}; jr_addr = bypassed rs data.
REQ-016 branch_taken = in_valid & ~stall & condition(br_op_id) on bypassed rs/rt (signed compares vs 0); 0 for br_op 0 or 7.
REQ-017 Hazard: haz = memread_ex & regwaddr_ex!=0 & (regwaddr_ex==rs | regwaddr_ex==rt) & in_valid.
REQ-018 On haz with counter 0, stall counter loads LOAD_LAT-1; stall = haz | counter!=0; counter decrements each cycle to 0.
REQ-019 stall also asserted when out_valid & ~ex_ready (backpressure).
REQ-020 in_ready = ~stall.
REQ-021 ID/EX register update: if out_valid & ~ex_ready hold all; else if stall due to hazard load bubble (out_valid=0, ctrl_ex=0); else load decoded bundle with out_valid=in_valid.
REQ-022 Bubble: ctrl_ex zeroed; data fields don't-care but deterministic (hold).
REQ-023 Latency: one cycle from accepted instruction to out_valid.

Reset
REQ-024 reset clears out_valid, ctrl_ex, stall counter, all ID/EX data/address outputs to 0 next edge, overriding stall/backpressure; register file contents not cleared.
REQ-025 Reset mid-stall: counter 0, stall drops unless haz recomputes true.

Configuration
REQ-026 Macro ID_FWD_WB_EN defined: rs/rt read data replaced by regwdata_wb when regwrite_wb & regwaddr_wb!=0 & address matches (same-cycle bypass).
REQ-027 Macro undefined: no bypass; haz additionally true when regwrite_wb & regwaddr_wb!=0 matches rs or rt (one-cycle stall).

Structure
REQ-028 Shared package id_pkg: br_op encodings, default parameter constants, ID/EX bundle struct.
REQ-029 One sub-module id_regfile (NREG x XLEN, zero register); bypass, hazard, ID/EX register in top.

Verification
REQ-030 Load r5 in EX (memread_ex=1, regwaddr_ex=5), instr rs=5, LOAD_LAT=2 -> stall 2 cycles, 2 bubbles, then out_valid=1 with instr.
REQ-031 WB writes r3=0xDEADBEEF same cycle instr reads rs=3 -> with ID_FWD_WB_EN rs_data_ex=0xDEADBEEF, 0 stalls; without, 1 stall then same value.
REQ-032 beq, rs=rt=0x10, next_pc_id=0x100, imm=0xFFFF -> branch_taken=1, branch_addr=0xFC.
REQ-033 bgtz with rs=0 -> taken 0; bltz rs=0x80000000 -> taken 1.
REQ-034 ex_ready=0 for 3 cycles while out_valid=1 -> outputs held, in_ready=0; reset asserted then -> out_valid=0 next edge.
REQ-035 Write r0=0x55 -> read rs=0 returns 0; hazard with regwaddr_ex=0 -> no stall.
